muldiv_unit: RTL and testbench

Sequencer and iterative datapath for the RV32M multiply/divide instructions in the EX stage of the pipelined CPU. It accepts an operation from the control unit and register file, runs a short multiply or a bit-serial divide, and holds the pipeline stalled until the result is ready. It returns a single 32-bit result with a one-cycle DONE pulse, and can be aborted by a pipeline flush.

---
 rtl/muldiv_unit_pkg.sv | 29 ++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit_div_step.sv | 28 ++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: FSM states, FUNCT3 op codes
// and a small sign helper used by both the unit and the M-extension decoder.
package muldiv_unit_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline control and the muldiv unit.
// start is a level held by EX until the op leaves; done is a one-cycle result-valid pulse.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   state_t          state_dbg;

   modport master (
      output start, funct3, operand_a, operand_b, flush,
      input  stall, busy, done, result, state_dbg
   );

   modport slave (
      input  start, funct3, operand_a, operand_b, flush,
      output stall, busy, done, result, state_dbg
   );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring radix-2 divide iteration: shift {rem, quo} left, trial-subtract the divisor.
module muldiv_unit_div_step
   import muldiv_unit_pkg::*;
(
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   always_comb begin
      rem_sh = {rem_in, quo_in[XLEN-1]};
      diff   = rem_sh - {1'b0, divisor};
      // A clear top bit means no borrow, so the divisor fits and the quotient bit is 1.
      if (!diff[XLEN]) begin
         rem_out = diff[XLEN-1:0];
         quo_out = {quo_in[XLEN-2:0], 1'b1};
      end else begin
         rem_out = rem_sh[XLEN-1:0];
         quo_out = {quo_in[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide sequencer: two-cycle multiply, 32-step restoring divide with
// sign fix-up, pipeline stall generation and flush abort.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   op_a_q, op_a_d;
   logic [XLEN-1:0]   op_b_q, op_b_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              stall;

   logic              is_div, div_signed, div_zero, div_ovf, a_neg, b_neg;
   logic [XLEN-1:0]   step_rem, step_quo;
   logic signed [2*XLEN-1:0] mul_a, mul_b, mul_p;
   logic [XLEN-1:0]   mul_res;

   muldiv_unit_div_step u_div_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (op_b_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   // Operands are widened with the per-op sign so a single signed multiply covers all four ops.
   always_comb begin
      mul_a = {{XLEN{((funct3_q == F3_MULH) || (funct3_q == F3_MULHSU)) & op_a_q[XLEN-1]}}, op_a_q};
      mul_b = {{XLEN{(funct3_q == F3_MULH) & op_b_q[XLEN-1]}}, op_b_q};
      mul_p = mul_a * mul_b;
      mul_res = (funct3_q == F3_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
   end

   always_comb begin
      is_div     = bus.funct3[2];
      div_signed = ~bus.funct3[0];
      div_zero   = (bus.operand_b == '0);
      div_ovf    = div_signed && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.operand_b == '1);
      a_neg      = div_signed & bus.operand_a[XLEN-1];
      b_neg      = div_signed & bus.operand_b[XLEN-1];
   end

   always_comb begin
      state_d  = state_q;
      funct3_d = funct3_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      stall    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               stall    = 1'b1;
               funct3_d = bus.funct3;
               op_a_d   = bus.operand_a;
               if (!is_div) begin
                  op_b_d  = bus.operand_b;
                  state_d = S_MUL;
               end else if (div_zero) begin
                  result_d = bus.funct3[1] ? bus.operand_a : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = bus.funct3[1] ? '0 : bus.operand_a;
                  state_d  = S_DONE;
               end else begin
                  op_b_d  = neg_if(b_neg, bus.operand_b);
                  quo_d   = neg_if(a_neg, bus.operand_a);
                  rem_d   = '0;
                  cnt_d   = CNT_W'(XLEN - 1);
                  q_neg_d = a_neg ^ b_neg;
                  r_neg_d = a_neg;
                  state_d = S_DIV;
               end
            end
         end
         S_MUL: begin
            stall    = 1'b1;
            result_d = mul_res;
            state_d  = S_DONE;
         end
         S_DIV: begin
            stall = 1'b1;
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FIX: begin
            stall    = 1'b1;
            result_d = funct3_q[1] ? neg_if(r_neg_q, rem_q) : neg_if(q_neg_q, quo_q);
            state_d  = S_DONE;
         end
         S_DONE: begin
            // START is still high for the retiring instruction, so it is not looked at here.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end

      busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         funct3_q <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         funct3_q <= funct3_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.stall     = stall;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, flush/reset aborts and random ops,
// with results checked from a queue against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   int              n_checks = 0;
   int              n_pass   = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] last_result;
   logic            prev_done = 1'b0;

   task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      int          sa, sb;
      longint      la, lb;
      logic [63:0] r;
      sa = a;
      sb = b;
      la = sa;
      lb = sb;
      case (f3)
         F3_MUL:    begin r = la * lb;                      return r[31:0];  end
         F3_MULH:   begin r = la * lb;                      return r[63:32]; end
         F3_MULHSU: begin r = la * longint'({32'b0, b});    return r[63:32]; end
         F3_MULHU:  begin r = {32'b0, a} * {32'b0, b};      return r[63:32]; end
         F3_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         F3_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         F3_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Cycle (counted from acceptance) in which DONE is expected.
   function automatic int ref_latency(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
      if (!f3[2]) return 2;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         check("done_pulse", {31'b0, prev_done}, 32'h0);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got result %h with nothing outstanding at %0t",
                     bus.result, $time);
         end else begin
            check("result", bus.result, exp_q.pop_front());
         end
      end
      prev_done = (bus.done === 1'b1);
   end

   // ---------------- driver tasks ----------------
   task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      int   lat, got_lat;
      logic stall_ok, busy_ok;
      lat         = ref_latency(f3, a, b);
      last_result = ref_result(f3, a, b);
      exp_q.push_back(last_result);
      @(posedge clk);
      #1;
      bus.funct3    = f3;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      got_lat  = -1;
      stall_ok = 1'b1;
      busy_ok  = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            got_lat = c;
            if (bus.stall !== 1'b0) stall_ok = 1'b0;
            if (bus.busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         if (bus.busy !== (c != 0)) busy_ok = 1'b0;
      end
      check("done_cycle", 32'(got_lat), 32'(lat));
      check("stall_window", {31'b0, stall_ok}, 32'h1);
      check("busy_window", {31'b0, busy_ok}, 32'h1);
      // START stays high across the edge that leaves DONE; it must not be re-accepted.
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("no_reaccept_state", 32'(bus.state_dbg), 32'(S_IDLE));
      check("result_held", bus.result, last_result);
   endtask

   task automatic flush_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      @(posedge clk);
      #1;
      bus.funct3    = f3;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("flush_state", 32'(bus.state_dbg), 32'(S_IDLE));
      check("flush_busy", {31'b0, bus.busy}, 32'h0);
      check("flush_done", {31'b0, bus.done}, 32'h0);
      check("flush_stall", {31'b0, bus.stall}, 32'h0);
      check("flush_result", bus.result, last_result);
   endtask

   task automatic start_with_flush();
      @(posedge clk);
      #1;
      bus.funct3    = F3_MUL;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd4;
      bus.start     = 1'b1;
      bus.flush     = 1'b1;
      @(negedge clk);
      check("flush_prio_stall", {31'b0, bus.stall}, 32'h0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_prio_state", 32'(bus.state_dbg), 32'(S_IDLE));
   endtask

   task automatic reset_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      @(posedge clk);
      #1;
      bus.funct3    = f3;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      last_result = '0;
      @(negedge clk);
      check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      check("rst_done", {31'b0, bus.done}, 32'h0);
      check("rst_result", bus.result, 32'h0);
   endtask

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.flush     = 1'b0;
      bus.funct3    = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      last_result   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_result", bus.result, 32'h0);
      check("reset_done", {31'b0, bus.done}, 32'h0);
      check("reset_busy", {31'b0, bus.busy}, 32'h0);
      check("reset_stall", {31'b0, bus.stall}, 32'h0);
      check("reset_state", 32'(bus.state_dbg), 32'(S_IDLE));

      run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD);
      run_op(F3_MULH,   32'h8000_0000,  32'h8000_0000);
      run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2);
      run_op(F3_REM,    32'hFFFF_FFF9,  32'd2);
      run_op(F3_DIVU,   32'd100,        32'd7);
      run_op(F3_REMU,   32'd100,        32'd7);
      run_op(F3_DIVU,   32'd5,          32'd0);
      run_op(F3_REM,    32'd5,          32'd0);
      run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
      run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF);

      flush_op(F3_DIV, 32'd1000, 32'd3);
      run_op(F3_REMU, 32'd1000, 32'd3);
      start_with_flush();
      reset_op(F3_DIV, 32'hDEAD_BEEF, 32'd17);
      run_op(F3_DIV, 32'hDEAD_BEEF, 32'd17);

      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
